// File: rtl/maxnet_ctrl_pkg.sv
// maxnet_ctrl_pkg: shared state encoding and default sizing for the Maxnet job controller.
package maxnet_ctrl_pkg;

   typedef enum logic [1:0] {IDLE, START, WAIT_DONE, HOLD} state_t;

   localparam int MAXNET_DATA_WIDTH     = 32;
   localparam int MAXNET_START_CYCLES   = 10;
   localparam int MAXNET_TIMEOUT_CYCLES = 4096;
   localparam int MAXNET_CNT_WIDTH      = 16;

endpackage

// File: rtl/maxnet_timeout_counter.sv
// maxnet_timeout_counter: clearable up-counter that flags the cycle it reaches LIMIT-1 while enabled.
module maxnet_timeout_counter #(
   parameter int CNT_WIDTH = 16,
   parameter int LIMIT     = 4096
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   logic [CNT_WIDTH-1:0] count;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)       count <= '0;
      else if (clear)  count <= '0;
      else if (enable) count <= count + CNT_WIDTH'(1);
   end

   assign expire = enable && (count == CNT_WIDTH'(LIMIT - 1));

endmodule

// File: rtl/maxnet_job_controller.sv
// maxnet_job_controller: drives the Maxnet start window, waits for an armed done with timeout,
// and hands the captured maximum downstream over valid/ready.
module maxnet_job_controller
   import maxnet_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH     = MAXNET_DATA_WIDTH,
   parameter int START_CYCLES   = MAXNET_START_CYCLES,
   parameter int TIMEOUT_CYCLES = MAXNET_TIMEOUT_CYCLES,
   parameter int CNT_WIDTH      = MAXNET_CNT_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  job_req,
   output logic                  job_ack,
   output logic                  start_signal,
   input  logic                  core_done,
   input  logic [DATA_WIDTH-1:0] core_max,
   output logic                  result_valid,
   output logic [DATA_WIDTH-1:0] result_data,
   input  logic                  result_ready,
   output logic                  busy,
   output logic                  timeout_err,
   output logic [CNT_WIDTH-1:0]  run_count
);

   state_t                state, state_n;
   logic                  ack_n, start_n, valid_n, busy_n, terr_n, armed_n;
   logic                  done_armed, done_ok, start_exp, time_exp, running;
   logic [DATA_WIDTH-1:0] data_n;
   logic [CNT_WIDTH-1:0]  count_n;

   assign running = (state == START) || (state == WAIT_DONE);
   assign done_ok = core_done && done_armed;

   maxnet_timeout_counter #(.CNT_WIDTH(CNT_WIDTH), .LIMIT(START_CYCLES)) u_start_window (
      .clock  (clock),
      .reset  (reset),
      .clear  (state != START),
      .enable (state == START),
      .expire (start_exp)
   );

   maxnet_timeout_counter #(.CNT_WIDTH(CNT_WIDTH), .LIMIT(TIMEOUT_CYCLES)) u_timeout (
      .clock  (clock),
      .reset  (reset),
      .clear  (!running),
      .enable (running),
      .expire (time_exp)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         job_ack      <= 1'b0;
         start_signal <= 1'b0;
         result_valid <= 1'b0;
         result_data  <= '0;
         busy         <= 1'b0;
         timeout_err  <= 1'b0;
         run_count    <= '0;
         done_armed   <= 1'b0;
      end else begin
         state        <= state_n;
         job_ack      <= ack_n;
         start_signal <= start_n;
         result_valid <= valid_n;
         result_data  <= data_n;
         busy         <= busy_n;
         timeout_err  <= terr_n;
         run_count    <= count_n;
         done_armed   <= armed_n;
      end
   end

   always_comb begin
      state_n = state;
      ack_n   = 1'b0;
      start_n = start_signal;
      valid_n = result_valid;
      data_n  = result_data;
      terr_n  = timeout_err;
      count_n = run_count;
      armed_n = done_armed;
      case (state)
         IDLE: if (job_req) begin
            state_n = START;
            ack_n   = 1'b1;
            start_n = 1'b1;
            terr_n  = 1'b0;
            armed_n = !core_done;
         end
         START, WAIT_DONE: begin
            // a done level left over from the previous run must fall before it counts
            armed_n = done_armed || !core_done;
            if (done_ok) begin
               state_n = HOLD;
               start_n = 1'b0;
               valid_n = 1'b1;
               data_n  = core_max;
               count_n = run_count + CNT_WIDTH'(1);
            end else if (time_exp) begin
               state_n = IDLE;
               start_n = 1'b0;
               terr_n  = 1'b1;
            end else if (state == START && start_exp) begin
               state_n = WAIT_DONE;
               start_n = 1'b0;
            end
         end
         HOLD: if (result_ready) begin
            state_n = IDLE;
            valid_n = 1'b0;
         end
         default: state_n = IDLE;
      endcase
      busy_n = state_n != IDLE;
   end

endmodule
